i2c_reg_seq_init: RTL and testbench
===================================

Name: i2c_reg_seq_init

Overview:
- Table-driven I2C register initialiser; parametrised successor to the fixed-list ADV7513 init sequencer.
- Walks a command table held in an external synchronous ROM. Each entry is a write, a write-with-readback-verify, a timed delay, or end-of-table.
- Drives the request side of the existing i2c_master. Retries NACKed or mismatched transactions and reports the failing entry index.
- Sits between board-level bring-up logic and i2c_master; serves any codec, HDMI TX or sensor configuration.

Parameters:
- CMD_COUNT, 64, table depth in entries; the table ends at an END op or index CMD_COUNT-1, whichever comes first.
- IDX_W, 6, table index width; must satisfy 2^IDX_W >= CMD_COUNT.
- MAX_RETRY, 3, extra attempts per entry after the first failure; 0 disables retry.
- DELAY_UNIT, 1000, clk cycles per delay tick.
- VERIFY_EN, 1, 0 makes op WRITE_VERIFY behave as plain WRITE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled in IDLE, DONE and ERROR
- rom_addr  out  IDX_W  table index; reset 0
- rom_data  in  25  {op[1:0], chip_addr[6:0], reg_addr[7:0], data[7:0]}; valid 1 cycle after rom_addr
- chip_addr  out  7  to i2c_master; reset 0
- reg_addr  out  8  to i2c_master; reset 0
- data_in  out  8  to i2c_master; reset 0
- write_en  out  1  1-cycle request pulse; reset 0
- read_en  out  1  1-cycle request pulse; reset 0
- i2c_done  in  1  1-cycle completion pulse from master
- i2c_status  in  3  master status; nonzero means error/NACK, sampled with i2c_done
- i2c_data_out  in  8  read data; valid with i2c_done
- busy  out  1  high outside IDLE/DONE/ERROR; reset 0
- done  out  1  level, high in DONE; reset 0
- error  out  1  level, high in ERROR; reset 0
- fail_idx  out  IDX_W  index of the entry that exhausted retries; reset 0

Behaviour:
- Op codes: 0 WRITE, 1 WRITE_VERIFY, 2 DELAY (ticks = {reg_addr,data}, 16 bits; 0 ticks = no wait), 3 END.
- States:
  - IDLE: on start, set rom_addr=0 and go to FETCH.
  - FETCH: wait 1 cycle for ROM data, then go to DECODE.
  - DECODE: latch the entry and clear the retry count.
    - WRITE or WRITE_VERIFY -> ISSUE_WR.
    - DELAY -> DELAY.
    - END -> DONE.
  - ISSUE_WR: drive chip_addr/reg_addr/data_in, pulse write_en for 1 cycle, then go to WAIT_WR.
  - WAIT_WR: on i2c_done:
    - status != 0 -> RETRY.
    - else if op==WRITE_VERIFY && VERIFY_EN -> ISSUE_RD.
    - else -> NEXT.
  - ISSUE_RD: pulse read_en for 1 cycle, then go to WAIT_RD.
  - WAIT_RD: on i2c_done:
    - status != 0 or i2c_data_out != data -> RETRY.
    - else -> NEXT.
  - RETRY: if the retry count < MAX_RETRY, increment it and return to ISSUE_WR. Otherwise set fail_idx=rom_addr and go to ERROR.
  - DELAY: 32-bit down-counter loaded with ticks*DELAY_UNIT; go to NEXT when it reaches 0.
  - NEXT: if rom_addr == CMD_COUNT-1, go to DONE. Otherwise increment rom_addr and go to FETCH.
  - DONE / ERROR: hold; start re-runs the table from index 0 and clears error/fail_idx.
- Latency: ISSUE_WR is entered 3 cycles after start is sampled. Between entries there is a 3-cycle gap (NEXT, FETCH, DECODE).
- i2c_done arriving outside the WAIT states is ignored. write_en and read_en are never asserted together.
- rom_addr never exceeds CMD_COUNT-1 (no wrap).
- Reset mid-transaction: all outputs return to reset values asynchronously and any pending request is dropped. The master is reset by the same signal.
- start held high through DONE causes a re-run. Callers must pulse start.

Decomposition:
- Shared package i2c_seq_pkg:
  - op-code constants OP_WRITE, OP_WRITE_VERIFY, OP_DELAY, OP_END.
  - entry field offsets and entry width 25.
  - state encodings.
- Natural sub-module: i2c_seq_delay, a loadable down-counter with a zero flag.
- The board wrapper, not this block, instantiates the ROM and i2c_master.

Test Plan:
- 3 WRITE entries then END, master model always ACKs -> three write_en pulses carrying (39,D6,C0), (39,41,10), (39,98,03); done=1, error=0, rom_addr=3.
- WRITE_VERIFY (39,AF,16), model returns 16 -> one write_en then one read_en; done=1.
- WRITE_VERIFY, model returns 12 on every read, MAX_RETRY=3 -> 4 write/read pairs; error=1, fail_idx=0, done=0.
- NACK on first write attempt only -> exactly 2 write_en pulses; sequence completes with done=1.
- DELAY ticks=2, DELAY_UNIT=10 -> exactly 20 cycles of no requests between the neighbouring writes.
- Assert reset while in WAIT_WR, then release and start -> outputs zero during reset; after start, the sequence restarts at index 0.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the table-driven I2C register initialiser.
//   - Op-code constants for the command table.
//   - Field offsets inside one 25-bit table entry:
//       {op[1:0], chip_addr[6:0], reg_addr[7:0], data[7:0]}
//     A DELAY entry reuses {reg_addr, data} as a 16-bit tick count.
//   - Sequencer state encoding.
package i2c_seq_pkg;

    localparam int ENTRY_W  = 25;

    localparam int OP_MSB   = 24;
    localparam int OP_LSB   = 23;
    localparam int CHIP_MSB = 22;
    localparam int CHIP_LSB = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [1:0] OP_WRITE        = 2'd0;
    localparam logic [1:0] OP_WRITE_VERIFY = 2'd1;
    localparam logic [1:0] OP_DELAY        = 2'd2;
    localparam logic [1:0] OP_END          = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_ISSUE_WR = 4'd3,
        ST_WAIT_WR  = 4'd4,
        ST_ISSUE_RD = 4'd5,
        ST_WAIT_RD  = 4'd6,
        ST_RETRY    = 4'd7,
        ST_DELAY    = 4'd8,
        ST_NEXT     = 4'd9,
        ST_DONE     = 4'd10,
        ST_ERROR    = 4'd11
    } seq_state_t;

    // Tick count carried by a DELAY entry.
    function automatic logic [15:0] entry_ticks(input logic [ENTRY_W-1:0] entry);
        return entry[REG_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/i2c_seq_delay.sv
// Loadable 32-bit down-counter used for the DELAY op.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   load      load load_val this cycle (has priority over en)
//   load_val  value to load
//   en        decrement by one while non-zero
//   zero      high while the count is zero
module i2c_seq_delay (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != 32'd0)) begin
            count_reg <= count_reg - 32'd1;
        end
    end

    assign zero = (count_reg == 32'd0);

endmodule

// File: rtl/i2c_reg_seq_init.sv
// Table-driven I2C register initialiser. Walks a command table in an external
// synchronous ROM and issues write / write-verify requests to i2c_master,
// with timed delays, per-entry retry and failing-entry reporting.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   start                 level, sampled in IDLE / DONE / ERROR
//   rom_addr, rom_data    table index out, entry in (1-cycle ROM latency)
//   chip_addr, reg_addr,
//   data_in               request fields to i2c_master
//   write_en, read_en     1-cycle request pulses
//   i2c_done, i2c_status,
//   i2c_data_out          completion pulse, status and read data from master
//   busy, done, error     sequencer status
//   fail_idx              entry index that exhausted its retries
module i2c_reg_seq_init
    import i2c_seq_pkg::*;
#(
    parameter int CMD_COUNT  = 64,
    parameter int IDX_W      = 6,
    parameter int MAX_RETRY  = 3,
    parameter int DELAY_UNIT = 1000,
    parameter int VERIFY_EN  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [6:0]         chip_addr,
    output logic [7:0]         reg_addr,
    output logic [7:0]         data_in,
    output logic               write_en,
    output logic               read_en,
    input  logic               i2c_done,
    input  logic [2:0]         i2c_status,
    input  logic [7:0]         i2c_data_out,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   fail_idx
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(CMD_COUNT - 1);

    seq_state_t state_reg, state_next;

    logic [IDX_W-1:0]   rom_addr_reg;
    logic [IDX_W-1:0]   fail_idx_reg;
    logic [1:0]         op_reg;
    logic [6:0]         chip_addr_reg;
    logic [7:0]         reg_addr_reg;
    logic [7:0]         data_in_reg;
    logic [RETRY_W-1:0] retry_cnt_reg;

    logic [1:0]  rom_op;
    logic [15:0] rom_ticks;
    logic [31:0] delay_load_val;
    logic        delay_load;
    logic        delay_en;
    logic        delay_zero;
    logic        verify_op;

    assign rom_op    = rom_data[OP_MSB:OP_LSB];
    assign rom_ticks = entry_ticks(rom_data);

    // The DELAY state's own exit cycle counts as one clock, so the counter is
    // loaded one short: the state then lasts exactly ticks*DELAY_UNIT cycles.
    // Zero ticks never enters DELAY, so the wrap of this value is never used.
    assign delay_load_val = (32'(rom_ticks) * 32'(DELAY_UNIT)) - 32'd1;

    assign verify_op = (op_reg == OP_WRITE_VERIFY) && (VERIFY_EN != 0);

    i2c_seq_delay u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (delay_load),
        .load_val (delay_load_val),
        .en       (delay_en),
        .zero     (delay_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and request/status outputs.
    always_comb begin
        state_next = state_reg;
        write_en   = 1'b0;
        read_en    = 1'b0;
        delay_load = 1'b0;
        delay_en   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_FETCH;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = ST_FETCH;
            end
            ST_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (rom_op)
                    OP_WRITE, OP_WRITE_VERIFY: state_next = ST_ISSUE_WR;
                    OP_DELAY: begin
                        if (rom_ticks == 16'd0) begin
                            state_next = ST_NEXT;
                        end else begin
                            state_next = ST_DELAY;
                            delay_load = 1'b1;
                        end
                    end
                    default: state_next = ST_DONE;
                endcase
            end
            ST_ISSUE_WR: begin
                write_en   = 1'b1;
                state_next = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                if (i2c_done) begin
                    if (i2c_status != 3'd0) begin
                        state_next = ST_RETRY;
                    end else if (verify_op) begin
                        state_next = ST_ISSUE_RD;
                    end else begin
                        state_next = ST_NEXT;
                    end
                end
            end
            ST_ISSUE_RD: begin
                read_en    = 1'b1;
                state_next = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (i2c_done) begin
                    if ((i2c_status != 3'd0) || (i2c_data_out != data_in_reg)) begin
                        state_next = ST_RETRY;
                    end else begin
                        state_next = ST_NEXT;
                    end
                end
            end
            ST_RETRY: begin
                if (retry_cnt_reg < MAX_RETRY_C) begin
                    state_next = ST_ISSUE_WR;
                end else begin
                    state_next = ST_ERROR;
                end
            end
            ST_DELAY: begin
                delay_en = 1'b1;
                if (delay_zero) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (rom_addr_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Table index, latched entry, retry bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_reg  <= '0;
            fail_idx_reg  <= '0;
            op_reg        <= OP_WRITE;
            chip_addr_reg <= '0;
            reg_addr_reg  <= '0;
            data_in_reg   <= '0;
            retry_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        rom_addr_reg <= '0;
                        fail_idx_reg <= '0;
                    end
                end
                ST_DECODE: begin
                    op_reg        <= rom_op;
                    retry_cnt_reg <= '0;
                    // Only request-bearing entries update the master-facing
                    // fields; a DELAY entry's tick count never reaches the bus.
                    if ((rom_op == OP_WRITE) || (rom_op == OP_WRITE_VERIFY)) begin
                        chip_addr_reg <= rom_data[CHIP_MSB:CHIP_LSB];
                        reg_addr_reg  <= rom_data[REG_MSB:REG_LSB];
                        data_in_reg   <= rom_data[DATA_MSB:DATA_LSB];
                    end
                end
                ST_RETRY: begin
                    if (retry_cnt_reg < MAX_RETRY_C) begin
                        retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                    end else begin
                        fail_idx_reg <= rom_addr_reg;
                    end
                end
                ST_NEXT: begin
                    if (rom_addr_reg != LAST_IDX) begin
                        rom_addr_reg <= rom_addr_reg + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign fail_idx  = fail_idx_reg;
    assign chip_addr = chip_addr_reg;
    assign reg_addr  = reg_addr_reg;
    assign data_in   = data_in_reg;

endmodule

// File: tb/tb_i2c_reg_seq_init.sv
// Self-checking bench for i2c_reg_seq_init: ROM model, i2c_master response
// model, request scoreboard and directed test sequence.
module tb_i2c_reg_seq_init;
    import i2c_seq_pkg::*;

    localparam int CMD_COUNT  = 64;
    localparam int IDX_W      = 6;
    localparam int MAX_RETRY  = 3;
    localparam int DELAY_UNIT = 10;
    localparam int RESP_LAT   = 3;
    localparam int GAP        = 3;   // NEXT, FETCH, DECODE

    typedef struct packed {
        logic       is_rd;
        logic [6:0] chip;
        logic [7:0] rg;
        logic [7:0] dat;
    } txn_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [IDX_W-1:0]   rom_addr;
    logic [ENTRY_W-1:0] rom_data;
    logic [6:0]         chip_addr;
    logic [7:0]         reg_addr;
    logic [7:0]         data_in;
    logic               write_en;
    logic               read_en;
    logic               i2c_done;
    logic [2:0]         i2c_status;
    logic [7:0]         i2c_data_out;
    logic               busy;
    logic               done;
    logic               error;
    logic [IDX_W-1:0]   fail_idx;

    logic [ENTRY_W-1:0] rom [0:CMD_COUNT-1];
    txn_t exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int wr_pulses    = 0;
    int rd_pulses    = 0;
    int last_done_cyc = 0;
    int last_gap     = 0;
    int nack_left    = 0;
    bit rd_bad       = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    i2c_reg_seq_init #(
        .CMD_COUNT  (CMD_COUNT),
        .IDX_W      (IDX_W),
        .MAX_RETRY  (MAX_RETRY),
        .DELAY_UNIT (DELAY_UNIT),
        .VERIFY_EN  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .chip_addr    (chip_addr),
        .reg_addr     (reg_addr),
        .data_in      (data_in),
        .write_en     (write_en),
        .read_en      (read_en),
        .i2c_done     (i2c_done),
        .i2c_status   (i2c_status),
        .i2c_data_out (i2c_data_out),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .fail_idx     (fail_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input logic [1:0] op, input logic [6:0] chip,
                                               input logic [7:0] rg, input logic [7:0] dat);
        return {op, chip, rg, dat};
    endfunction

    function automatic txn_t wr(input logic [6:0] chip, input logic [7:0] rg, input logic [7:0] dat);
        return '{is_rd: 1'b0, chip: chip, rg: rg, dat: dat};
    endfunction

    function automatic txn_t rd(input logic [6:0] chip, input logic [7:0] rg, input logic [7:0] dat);
        return '{is_rd: 1'b1, chip: chip, rg: rg, dat: dat};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < CMD_COUNT; i++) rom[i] = mk(OP_END, 7'h0, 8'h0, 8'h0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done || error), 32'd1);
        @(negedge clk);
    endtask

    // i2c_master model and request monitor: each request is checked against
    // the scoreboard head, and answered with i2c_done RESP_LAT cycles later.
    initial begin
        int   pend;
        logic pend_rd;
        logic [7:0] last_wr;
        txn_t t;
        pend = 0;
        pend_rd = 1'b0;
        last_wr = 8'h00;
        i2c_done = 1'b0;
        i2c_status = 3'd0;
        i2c_data_out = 8'h00;
        forever begin
            @(negedge clk);
            i2c_done   = 1'b0;
            i2c_status = 3'd0;
            if (!reset) begin
                pend = 0;
            end else if (write_en || read_en) begin
                check("wr_rd_exclusive", 32'(write_en && read_en), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_request", 32'({read_en, chip_addr, reg_addr, data_in}), 32'hFFFFFFFF);
                end else begin
                    t = exp_q.pop_front();
                    check("request_fields", 32'({read_en, chip_addr, reg_addr, data_in}), 32'(t));
                end
                if (write_en) begin
                    wr_pulses++;
                    last_gap = cyc - last_done_cyc - 1;
                    last_wr  = data_in;
                end else begin
                    rd_pulses++;
                end
                pend    = RESP_LAT;
                pend_rd = read_en;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i2c_done = 1'b1;
                    last_done_cyc = cyc;
                    if (pend_rd) begin
                        i2c_data_out = rd_bad ? 8'h12 : last_wr;
                    end else if (nack_left > 0) begin
                        i2c_status = 3'd1;
                        nack_left--;
                    end
                end
            end
        end
    end

    initial begin
        int w0, r0, s_cyc, n;
        reset = 1'b0;
        start = 1'b0;
        clear_rom();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, error, write_en, read_en, rom_addr, fail_idx}), 32'd0);
        check("reset_fields", 32'({chip_addr, reg_addr, data_in}), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({busy, done, error}), 32'd0);

        // Three plain writes then END; start latency and inter-entry gap
        rom[0] = mk(OP_WRITE, 7'h39, 8'hD6, 8'hC0);
        rom[1] = mk(OP_WRITE, 7'h39, 8'h41, 8'h10);
        rom[2] = mk(OP_WRITE, 7'h39, 8'h98, 8'h03);
        exp_q.push_back(wr(7'h39, 8'hD6, 8'hC0));
        exp_q.push_back(wr(7'h39, 8'h41, 8'h10));
        exp_q.push_back(wr(7'h39, 8'h98, 8'h03));
        w0 = wr_pulses;
        @(negedge clk) start = 1'b1;
        s_cyc = cyc;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!write_en && n < 20) begin @(negedge clk); n++; end
        check("start_latency", 32'(cyc - s_cyc), 32'd3);
        wait_end("t1_timeout", 200);
        check("t1_done_error", 32'({done, error}), 32'b10);
        check("t1_rom_addr", 32'(rom_addr), 32'd3);
        check("t1_writes", 32'(wr_pulses - w0), 32'd3);
        check("t1_gap", 32'(last_gap), 32'(GAP));
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Write-verify, readback matches
        clear_rom();
        rom[0] = mk(OP_WRITE_VERIFY, 7'h39, 8'hAF, 8'h16);
        exp_q.push_back(wr(7'h39, 8'hAF, 8'h16));
        exp_q.push_back(rd(7'h39, 8'hAF, 8'h16));
        w0 = wr_pulses; r0 = rd_pulses;
        pulse_start();
        wait_end("t2_timeout", 200);
        check("t2_done_error", 32'({done, error}), 32'b10);
        check("t2_counts", 32'({16'(wr_pulses - w0), 16'(rd_pulses - r0)}), {16'd1, 16'd1});
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Verify mismatch on every read at index 2 -> retries exhausted
        rd_bad = 1'b1;
        rom[0] = mk(OP_WRITE, 7'h39, 8'h01, 8'h11);
        rom[1] = mk(OP_WRITE, 7'h39, 8'h02, 8'h22);
        rom[2] = mk(OP_WRITE_VERIFY, 7'h39, 8'hAF, 8'h16);
        exp_q.push_back(wr(7'h39, 8'h01, 8'h11));
        exp_q.push_back(wr(7'h39, 8'h02, 8'h22));
        for (int i = 0; i <= MAX_RETRY; i++) begin
            exp_q.push_back(wr(7'h39, 8'hAF, 8'h16));
            exp_q.push_back(rd(7'h39, 8'hAF, 8'h16));
        end
        w0 = wr_pulses; r0 = rd_pulses;
        pulse_start();
        wait_end("t3_timeout", 400);
        check("t3_done_error", 32'({done, error}), 32'b01);
        check("t3_fail_idx", 32'(fail_idx), 32'd2);
        check("t3_counts", 32'({16'(wr_pulses - w0), 16'(rd_pulses - r0)}), {16'd6, 16'd4});
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same failure at index 0; start from ERROR clears fail_idx
        clear_rom();
        rom[0] = mk(OP_WRITE_VERIFY, 7'h39, 8'hAF, 8'h16);
        for (int i = 0; i <= MAX_RETRY; i++) begin
            exp_q.push_back(wr(7'h39, 8'hAF, 8'h16));
            exp_q.push_back(rd(7'h39, 8'hAF, 8'h16));
        end
        w0 = wr_pulses; r0 = rd_pulses;
        pulse_start();
        check("t3b_fail_idx_cleared", 32'(fail_idx), 32'd0);
        check("t3b_error_cleared", 32'(error), 32'd0);
        wait_end("t3b_timeout", 400);
        check("t3b_done_error", 32'({done, error}), 32'b01);
        check("t3b_fail_idx", 32'(fail_idx), 32'd0);
        check("t3b_counts", 32'({16'(wr_pulses - w0), 16'(rd_pulses - r0)}), {16'd4, 16'd4});
        rd_bad = 1'b0;

        // NACK on first attempt only
        clear_rom();
        rom[0] = mk(OP_WRITE, 7'h39, 8'hD6, 8'hC0);
        exp_q.push_back(wr(7'h39, 8'hD6, 8'hC0));
        exp_q.push_back(wr(7'h39, 8'hD6, 8'hC0));
        nack_left = 1;
        w0 = wr_pulses;
        pulse_start();
        wait_end("t4_timeout", 200);
        check("t4_done_error", 32'({done, error}), 32'b10);
        check("t4_writes", 32'(wr_pulses - w0), 32'd2);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Delay of 2 ticks and of 0 ticks between two writes
        for (int k = 0; k < 2; k++) begin
            logic [7:0] ticks;
            ticks = (k == 0) ? 8'd2 : 8'd0;
            clear_rom();
            rom[0] = mk(OP_WRITE, 7'h39, 8'h10, 8'hAA);
            rom[1] = mk(OP_DELAY, 7'h00, 8'h00, ticks);
            rom[2] = mk(OP_WRITE, 7'h39, 8'h11, 8'hBB);
            exp_q.push_back(wr(7'h39, 8'h10, 8'hAA));
            exp_q.push_back(wr(7'h39, 8'h11, 8'hBB));
            pulse_start();
            wait_end("t5_timeout", 300);
            check("t5_done", 32'(done), 32'd1);
            check("t5_delay_gap", 32'(last_gap), 32'(2 * GAP + int'(ticks) * DELAY_UNIT));
            check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Full table with no END: stops at the last index
        for (int i = 0; i < CMD_COUNT; i++) begin
            rom[i] = mk(OP_WRITE, 7'h39, 8'(i), ~8'(i));
            exp_q.push_back(wr(7'h39, 8'(i), ~8'(i)));
        end
        w0 = wr_pulses;
        pulse_start();
        wait_end("t6_timeout", 3000);
        check("t6_done", 32'(done), 32'd1);
        check("t6_rom_addr", 32'(rom_addr), 32'(CMD_COUNT - 1));
        check("t6_writes", 32'(wr_pulses - w0), 32'(CMD_COUNT));
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted in WAIT_WR, then restart from index 0
        clear_rom();
        rom[0] = mk(OP_WRITE, 7'h39, 8'hD6, 8'hC0);
        rom[1] = mk(OP_WRITE, 7'h39, 8'h41, 8'h10);
        rom[2] = mk(OP_WRITE, 7'h39, 8'h98, 8'h03);
        exp_q.push_back(wr(7'h39, 8'hD6, 8'hC0));
        pulse_start();
        n = 0;
        while (!write_en && n < 20) begin @(negedge clk); n++; end
        check("t7_first_write_seen", 32'(write_en), 32'd1);
        @(negedge clk) reset = 1'b0;
        #1;
        check("t7_reset_outputs", 32'({busy, done, error, write_en, read_en, rom_addr, fail_idx}), 32'd0);
        check("t7_reset_fields", 32'({chip_addr, reg_addr, data_in}), 32'd0);
        repeat (RESP_LAT + 2) @(negedge clk);
        check("t7_held_in_reset", 32'({busy, write_en, read_en}), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t7_idle_after_release", 32'({busy, done, error}), 32'd0);
        exp_q.push_back(wr(7'h39, 8'hD6, 8'hC0));
        exp_q.push_back(wr(7'h39, 8'h41, 8'h10));
        exp_q.push_back(wr(7'h39, 8'h98, 8'h03));
        w0 = wr_pulses;
        pulse_start();
        wait_end("t7_timeout", 200);
        check("t7_done", 32'({done, error}), 32'b10);
        check("t7_rom_addr", 32'(rom_addr), 32'd3);
        check("t7_writes", 32'(wr_pulses - w0), 32'd3);
        check("t7_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
